// File: rtl/ysyx_22051086_divider_if.sv
// ysyx_22051086_divider_if: request/result bundle between the EXU and the radix-2 divider.
interface ysyx_22051086_divider_if #(parameter int XLEN = 64);
    logic            div_valid;
    logic            flush;
    logic            divw;
    logic            div_signed;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_ready;
    logic            out_valid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    modport master (
        output div_valid, flush, divw, div_signed, dividend, divisor,
        input  div_ready, out_valid, quotient, remainder
    );
    modport slave (
        input  div_valid, flush, divw, div_signed, dividend, divisor,
        output div_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_22051086_divider.sv
// ysyx_22051086_divider: multi-cycle restoring divider for DIV/DIVU/REM/REMU and their W forms.
module ysyx_22051086_divider #(
    parameter int XLEN = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ysyx_22051086_divider_if.slave  div_if
);
    localparam int H  = XLEN / 2;
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, acc_q, acc_d;
    logic [XLEN-1:0] quot_q, quot_d, rmd_q, rmd_d;
    logic            w_q, w_d, nq_q, nq_d, nr_q, nr_d;
    logic [XLEN-1:0] ea, eb, ma, mb, minv, rem_n, acc_n, q_fix, r_fix;
    logic [XLEN:0]   rem_sh;
    logic            sa, sb, zero, ovf, ge, last;

    function automatic logic [XLEN-1:0] fit(input logic w, input logic s, input logic [XLEN-1:0] x);
        return w ? {{H{s & x[H-1]}}, x[H-1:0]} : x;
    endfunction

    assign ea     = fit(div_if.divw, div_if.div_signed, div_if.dividend);
    assign eb     = fit(div_if.divw, div_if.div_signed, div_if.divisor);
    assign sa     = div_if.div_signed & ea[XLEN-1];
    assign sb     = div_if.div_signed & eb[XLEN-1];
    assign ma     = sa ? -ea : ea;
    assign mb     = sb ? -eb : eb;
    assign minv   = div_if.divw ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign zero   = eb == '0;
    assign ovf    = div_if.div_signed & (eb == '1) & (ea == minv);
    // One restoring step: the dividend magnitude is shifted out MSB first from a_q.
    assign rem_sh = {rem_q, a_q[XLEN-1]};
    assign ge     = rem_sh >= {1'b0, b_q};
    assign rem_n  = ge ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0];
    assign acc_n  = {acc_q[XLEN-2:0], ge};
    assign q_fix  = nq_q ? -acc_n : acc_n;
    assign r_fix  = nr_q ? -rem_n : rem_n;
    assign last   = cnt_q == CW'(w_q ? H - 1 : XLEN - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        w_d     = w_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        if (div_if.flush) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (div_if.div_valid) begin
                w_d     = div_if.divw;
                nq_d    = sa ^ sb;
                nr_d    = sa;
                a_d     = div_if.divw ? {ma[H-1:0], {H{1'b0}}} : ma;
                b_d     = mb;
                rem_d   = '0;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = (zero | ovf) ? WAIT : RUN;
                if (zero | ovf) begin
                    quot_d = zero ? '1 : fit(div_if.divw, 1'b1, div_if.dividend);
                    rmd_d  = zero ? fit(div_if.divw, 1'b1, div_if.dividend) : '0;
                end
            end
        end else if (state_q == RUN) begin
            a_d   = a_q << 1;
            rem_d = rem_n;
            acc_d = acc_n;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d = WAIT;
                quot_d  = fit(w_q, 1'b1, q_fix);
                rmd_d   = fit(w_q, 1'b1, r_fix);
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            w_q     <= 1'b0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            w_q     <= w_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
        end
    end

    assign div_if.div_ready = state_q == IDLE;
    assign div_if.out_valid = (state_q == WAIT) & ~div_if.flush;
    assign div_if.quotient  = quot_q;
    assign div_if.remainder = rmd_q;
endmodule

// File: tb/tb_ysyx_22051086_divider.sv
// tb_ysyx_22051086_divider: randomized and directed checks of the divider against an arithmetic model.
module tb_ysyx_22051086_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ysyx_22051086_divider_if #(.XLEN(64)) dif ();
    ysyx_22051086_divider #(.XLEN(64)) dut (.clk(clk), .rst_n(rst_n), .div_if(dif));

    always #5 clk = ~clk;

    function automatic void ref_div(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] q, output logic [63:0] r, output int lat);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        lat = w ? 33 : 65;
        if (w) begin
            if (b32 == 0) begin q32 = '1; r32 = a32; lat = 1; end
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; lat = 1; end
            else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 0) begin q = '1; r = a; lat = 1; end
            else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; lat = 1; end
            else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
            else begin q = a / b; r = a % b; end
        end
    endfunction

    task automatic run_op(input string name, input logic w, input logic s, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] eq, er;
        int elat, lat;
        ref_div(w, s, a, b, eq, er, elat);
        dif.divw = w; dif.div_signed = s; dif.dividend = a; dif.divisor = b; dif.div_valid = 1'b1;
        @(posedge clk);
        #1;
        dif.div_valid = 1'b0;
        dif.divw = ~w; dif.div_signed = ~s;
        dif.dividend = {$urandom, $urandom}; dif.divisor = {$urandom, $urandom};
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (dif.out_valid) begin lat = c; break; end
        end
        checks++;
        if (lat !== elat) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat); end
        checks++;
        if (dif.quotient !== eq) begin errors++; $display("FAIL %s quotient got=%h exp=%h", name, dif.quotient, eq); end
        checks++;
        if (dif.remainder !== er) begin errors++; $display("FAIL %s remainder got=%h exp=%h", name, dif.remainder, er); end
        @(negedge clk);
        checks++;
        if (dif.out_valid !== 1'b0 || dif.div_ready !== 1'b1) begin
            errors++; $display("FAIL %s pulse_end out_valid=%b div_ready=%b exp 0/1", name, dif.out_valid, dif.div_ready);
        end
    endtask

    task automatic test_reset();
        checks += 4;
        if (dif.div_ready !== 1'b1) begin errors++; $display("FAIL reset div_ready got=%b exp=1", dif.div_ready); end
        if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", dif.out_valid); end
        if (dif.quotient !== 64'd0) begin errors++; $display("FAIL reset quotient got=%h exp=0", dif.quotient); end
        if (dif.remainder !== 64'd0) begin errors++; $display("FAIL reset remainder got=%h exp=0", dif.remainder); end
    endtask

    task automatic test_directed();
        run_op("divu_100_7", 0, 0, 64'd100, 64'd7);
        run_op("div_m7_2", 0, 1, -64'sd7, 64'd2);
        run_op("div_7_m2", 0, 1, 64'd7, -64'sd2);
        run_op("div_5_0", 0, 1, 64'd5, 64'd0);
        run_op("divw_5_0", 1, 1, 64'd5, 64'hABCD_0000_0000_0000);
        run_op("div_ovf", 0, 1, 64'h8000_0000_0000_0000, '1);
        run_op("divw_ovf", 1, 1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF);
        run_op("divuw_max_1", 1, 0, 64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_0000_0001);
        run_op("remu_max", 0, 0, '1, 64'h8000_0000_0000_0000);
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(63, 0);
            if ($urandom_range(9, 0) == 0) b = 64'd0;
            run_op("random", 1'($urandom), 1'($urandom), a, b);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_0", 1, 1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        run_op("b2b_1", 1, 0, 64'd1000, 64'd10);
        run_op("b2b_2", 0, 1, -64'sd1000001, -64'sd3);
    endtask

    task automatic test_flush();
        int seen;
        dif.divw = 0; dif.div_signed = 0; dif.dividend = 64'd12345; dif.divisor = 64'd11; dif.div_valid = 1'b1;
        @(posedge clk);
        #1 dif.div_valid = 1'b0;
        repeat (10) @(negedge clk);
        dif.flush = 1'b1;
        checks++;
        if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid_during got=%b exp=0", dif.out_valid); end
        @(negedge clk);
        dif.flush = 1'b0;
        seen = 0;
        for (int c = 0; c < 70; c++) begin
            if (dif.out_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush stale_out_valid got=%0d exp=0", seen); end
        run_op("divu_9_3_after_flush", 0, 0, 64'd9, 64'd3);
        dif.div_valid = 1'b1; dif.flush = 1'b1; dif.divisor = 64'd3;
        @(negedge clk);
        dif.div_valid = 1'b0; dif.flush = 1'b0;
        checks++;
        if (dif.div_ready !== 1'b1) begin errors++; $display("FAIL flush_wins div_ready got=%b exp=1", dif.div_ready); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        dif.divw = 0; dif.div_signed = 1; dif.dividend = 64'd999; dif.divisor = 64'd4; dif.div_valid = 1'b1;
        @(posedge clk);
        #1 dif.div_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (dif.div_ready !== 1'b1) begin errors++; $display("FAIL rst_mid div_ready got=%b exp=1", dif.div_ready); end
        if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got=%b exp=0", dif.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (dif.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_mid spurious_out_valid got=%0d exp=0", seen); end
        run_op("after_rst", 0, 1, -64'sd50, 64'd6);
    endtask

    initial begin
        dif.div_valid = 1'b0; dif.flush = 1'b0; dif.divw = 1'b0; dif.div_signed = 1'b0;
        dif.dividend = '0; dif.divisor = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
